// File: rtl/vga_scan_controller.sv
// vga_scan_controller: 640x480@60 raster timing that reads a 128x96 1bpp RGB VRAM upscaled 5x5.
// Timing is parameterised; the defaults give the standard 25 MHz-pixel mode from a 100 MHz clock.
module vga_scan_controller #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 5
) (
    input  logic        clk,
    input  logic        reset,
    output logic [13:0] addr,
    input  logic        red_in,
    input  logic        green_in,
    input  logic        blue_in,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [2:0] SL  = 3'(SCALE - 1);

    logic [DW-1:0] div;
    logic [9:0]    hcnt, vcnt, hcnt_n, vcnt_n;
    logic [2:0]    hsub, vsub, hsub_n, vsub_n;
    logic [6:0]    col, row, col_n, row_n;
    logic          tick, h_wrap, v_wrap, active;

    // Next-pixel counter values; the address is derived from these so it tracks hcnt/vcnt exactly.
    always_comb begin
        tick   = div == DIV_LAST;
        h_wrap = hcnt == HL;
        v_wrap = vcnt == VL;
        active = hcnt < HA && vcnt < VA;
        hcnt_n = h_wrap ? 10'd0 : hcnt + 10'd1;
        hsub_n = (h_wrap || hsub == SL) ? 3'd0 : hsub + 3'd1;
        col_n  = h_wrap ? 7'd0 : (hsub == SL && col != 7'h7f) ? col + 7'd1 : col;
        vcnt_n = !h_wrap ? vcnt : v_wrap ? 10'd0 : vcnt + 10'd1;
        vsub_n = !h_wrap ? vsub : (v_wrap || vsub == SL) ? 3'd0 : vsub + 3'd1;
        row_n  = !h_wrap ? row : v_wrap ? 7'd0 : (vsub == SL && row != 7'h7f) ? row + 7'd1 : row;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div       <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
            hsub      <= '0;
            vsub      <= '0;
            col       <= '0;
            row       <= '0;
            addr      <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            vga_red   <= 4'h0;
            vga_green <= 4'h0;
            vga_blue  <= 4'h0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                hcnt      <= hcnt_n;
                vcnt      <= vcnt_n;
                hsub      <= hsub_n;
                vsub      <= vsub_n;
                col       <= col_n;
                row       <= row_n;
                addr      <= {vcnt_n < VA ? row_n : 7'd0, hcnt_n < HA ? col_n : 7'd0};
                // Sync and colour come from the pre-advance counters so they stay aligned.
                hsync     <= !(hcnt >= HS0 && hcnt <= HS1);
                vsync     <= !(vcnt >= VS0 && vcnt <= VS1);
                vga_red   <= (active && red_in) ? 4'hf : 4'h0;
                vga_green <= (active && green_in) ? 4'hf : 4'h0;
                vga_blue  <= (active && blue_in) ? 4'hf : 4'h0;
            end
        end
    end
endmodule
